// File: rtl/board_render_engine.sv
// rtl/board_render_engine.sv - snapshot an N x N board and stream its cells as VGA plot pixels
module board_render_engine #(
    parameter int         BOARD_N    = 3,
    parameter int         CELL_W     = 26,
    parameter int         GAP        = 2,
    parameter int         ORIGIN_X   = 4,
    parameter int         ORIGIN_Y   = 4,
    parameter logic [2:0] COL_EMPTY  = 3'b000,
    parameter logic [2:0] COL_P1     = 3'b100,
    parameter logic [2:0] COL_P2     = 3'b001,
    parameter logic [2:0] COL_HI     = 3'b110,
    parameter logic [2:0] COL_BORDER = 3'b111
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic                           full_redraw,
    input  logic [2*BOARD_N*BOARD_N-1:0]   grid,
    output logic [7:0]                     x_out,
    output logic [6:0]                     y_out,
    output logic [2:0]                     colour_out,
    output logic                           plot,
    output logic                           busy,
    output logic                           done
);
    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int KW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int PITCH = CELL_W + GAP;
    localparam int EXT_X = ORIGIN_X + BOARD_N * CELL_W + (BOARD_N - 1) * GAP;
    localparam int EXT_Y = ORIGIN_Y + BOARD_N * CELL_W + (BOARD_N - 1) * GAP;

    // Reject geometries that would run off the 160x120 plot area.
    generate
        if (EXT_X > 160 || EXT_Y > 120) begin : g_bad_geometry
            $error("board_render_engine: board does not fit the 160x120 plot area");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DRAW, FIN} state_t;

    state_t                  state;
    logic [CELLS-1:0][1:0]   snap;
    logic [CELLS-1:0][1:0]   shadow;
    logic                    shadow_valid;
    logic                    mode;
    logic [KW-1:0]           k;
    logic [2:0]              row;
    logic [2:0]              col;
    logic [4:0]              px;
    logic [4:0]              py;

    logic [7:0]              x_pix;
    logic [6:0]              y_pix;
    logic [2:0]              fill;
    logic [2:0]              pix_colour;
    logic                    on_border;
    logic                    last_cell;
    logic                    cell_dirty;
    logic                    last_pixel;
    logic [KW-1:0]           k_nx;
    logic [2:0]              row_nx;
    logic [2:0]              col_nx;

    // Pixel position/colour of the current (px, py) and the next cell index.
    always_comb begin
        x_pix      = 8'(ORIGIN_X) + 8'(col) * 8'(PITCH) + 8'(px);
        y_pix      = 7'(ORIGIN_Y) + 7'(row) * 7'(PITCH) + 7'(py);
        on_border  = (px == 5'd0) || (py == 5'd0) ||
                     (px == 5'(CELL_W - 1)) || (py == 5'(CELL_W - 1));
        case (snap[k])
            2'b00:   fill = COL_EMPTY;
            2'b01:   fill = COL_P1;
            2'b10:   fill = COL_P2;
            default: fill = COL_HI;
        endcase
        pix_colour = on_border ? COL_BORDER : fill;
        last_cell  = (k == KW'(CELLS - 1));
        cell_dirty = mode || (snap[k] != shadow[k]);
        last_pixel = (px == 5'(CELL_W - 1)) && (py == 5'(CELL_W - 1));
        k_nx       = k + 1'b1;
        if (col == 3'(BOARD_N - 1)) begin
            col_nx = 3'd0;
            row_nx = row + 3'd1;
        end else begin
            col_nx = col + 3'd1;
            row_nx = row;
        end
    end

    // Frame sequencer: snapshot, per-cell scan, pixel raster, completion pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            snap         <= '0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            mode         <= 1'b0;
            k            <= '0;
            row          <= 3'd0;
            col          <= 3'd0;
            px           <= 5'd0;
            py           <= 5'd0;
            x_out        <= 8'd0;
            y_out        <= 7'd0;
            colour_out   <= 3'd0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap  <= grid;
                        mode  <= full_redraw | ~shadow_valid;
                        k     <= '0;
                        row   <= 3'd0;
                        col   <= 3'd0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (cell_dirty) begin
                        px    <= 5'd0;
                        py    <= 5'd0;
                        state <= DRAW;
                    end else if (last_cell) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        k   <= k_nx;
                        row <= row_nx;
                        col <= col_nx;
                    end
                end
                DRAW: begin
                    plot       <= 1'b1;
                    x_out      <= x_pix;
                    y_out      <= y_pix;
                    colour_out <= pix_colour;
                    if (last_pixel) begin
                        shadow[k] <= snap[k];
                        if (last_cell) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            k     <= k_nx;
                            row   <= row_nx;
                            col   <= col_nx;
                            state <= SCAN;
                        end
                    end else if (px == 5'(CELL_W - 1)) begin
                        px <= 5'd0;
                        py <= py + 5'd1;
                    end else begin
                        px <= px + 5'd1;
                    end
                end
                FIN: begin
                    shadow_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
